// File: rtl/kamikaze_regfile_np.sv
// Integer register file for the kamikaze core with x0 hardwired to zero and a clear sequencer.
// Optional same-cycle write-to-read bypass when KAMIKAZE_REGFILE_BYPASS_EN is defined.
module kamikaze_regfile_np #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NREAD = 2,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [XLEN-1:0]       wdata_i,
    input  logic [NREAD*AW-1:0]   raddr_i,
    output logic [NREAD*XLEN-1:0] rdata_o,
    output logic                  ready_o
);

    typedef enum logic [0:0] {StClear, StReady} state_e;

    localparam logic [AW-1:0] LastIdx  = AW'(NREGS - 1);
    localparam logic [AW-1:0] FirstIdx = AW'(1);

    state_e            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              clr_we;
    logic              wr_en;
    logic [XLEN-1:0]   mem_q [NREGS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StClear;
            cnt_q   <= FirstIdx;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        wr_en   = 1'b0;
        unique case (state_q)
            StClear: begin
                // A restart edge only reloads the counter; no register is zeroed on it.
                if (clr_i) begin
                    cnt_d = FirstIdx;
                end else begin
                    clr_we = 1'b1;
                    if (cnt_q == LastIdx) begin
                        state_d = StReady;
                    end else begin
                        cnt_d = cnt_q + FirstIdx;
                    end
                end
            end
            StReady: begin
                if (clr_i) begin
                    state_d = StClear;
                    cnt_d   = FirstIdx;
                end else begin
                    wr_en = we_i && (waddr_i != '0);
                end
            end
            default: begin
                state_d = StClear;
                cnt_d   = FirstIdx;
            end
        endcase
    end

    // Array has no reset: contents are only meaningful once the clear has completed.
    always_ff @(posedge clk_i) begin
        if (clr_we) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_en) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign ready_o = (state_q == StReady);

`ifdef KAMIKAZE_REGFILE_BYPASS_EN
    logic byp_valid;
    assign byp_valid = ready_o && we_i && (waddr_i != '0);
`endif

    for (genvar p = 0; p < int'(NREAD); p++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] lane;

        assign ra = raddr_i[p*AW +: AW];

        always_comb begin
            lane = '0;
            if (ready_o && (ra != '0)) begin
`ifdef KAMIKAZE_REGFILE_BYPASS_EN
                if (byp_valid && (ra == waddr_i)) begin
                    lane = wdata_i;
                end else begin
                    lane = mem_q[ra];
                end
`else
                lane = mem_q[ra];
`endif
            end
        end

        assign rdata_o[p*XLEN +: XLEN] = lane;
    end

endmodule

// File: doc/kamikaze_regfile_np.md
# kamikaze_regfile_np

Parametrised integer register file for the kamikaze core: configurable data width, register count and number of read ports. It has a hardware clear sequencer that zeroes the whole array after reset or on request, and an optional write-to-read bypass. It sits between decode (read addresses) and writeback (single write port), and drives a ready flag that stalls issue while the clear runs.

## Interface
- XLEN, 32: data width in bits.
- NREGS, 32: number of architectural registers; power of two, ≥4. AW = $clog2(NREGS).
- NREAD, 2: number of read ports, 1..4.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- clr_i  in  1  soft clear request, sampled on rising edge.
- we_i  in  1  write enable.
- waddr_i  in  AW  write address.
- wdata_i  in  XLEN  write data.
- raddr_i  in  NREAD*AW  packed read addresses; port p uses bits [p*AW +: AW].
- rdata_o  out  NREAD*XLEN  packed read data; port p uses bits [p*XLEN +: XLEN].
- ready_o  out  1  high when the array is usable; low during reset and clear.

## Operation
- Register 0 is hardwired to zero. A read of address 0 returns 0. A write to address 0 is discarded.
- FSM has two states, CLEAR and READY.
  - Reset forces CLEAR, clear counter cnt = 1, ready_o = 0.
  - In CLEAR, each rising edge writes 0 to mem[cnt] and increments cnt.
  - When the edge that clears mem[NREGS-1] occurs, the FSM moves to READY and ready_o goes to 1.
  - In READY, clr_i = 1 at an edge moves to CLEAR with cnt = 1.
  - In CLEAR, clr_i = 1 at an edge restarts the clear with cnt = 1 and does not clear any register on that edge.
- Writes in READY: if we_i = 1 and waddr_i ≠ 0, mem[waddr_i] ← wdata_i at the edge.
- Writes in CLEAR, including the edge that enters CLEAR via clr_i, are ignored. They are not queued or retried.
- Reads are combinational and independent per port. Ports may share an address.
- While ready_o = 0, every rdata_o lane is forced to 0.
- cnt is AW bits wide and never wraps. The transition to READY happens at cnt = NREGS-1.
- An async reset mid-clear or mid-write aborts immediately. Array contents are then undefined until the restarted clear completes. Callers must not rely on contents while ready_o = 0.

## Timing
- Reset values: ready_o = 0; rdata_o = all zeros; FSM = CLEAR; cnt = 1.
- Clear duration is exactly NREGS-1 rising edges after rst_ni deasserts. ready_o rises after the (NREGS-1)th edge.
- A soft clear also takes NREGS-1 edges, counted from the edge after the one that samples clr_i. ready_o falls after the sampling edge.
- Write-to-read latency:
  - Without bypass, a written value is visible on rdata_o after the write edge (1 cycle).
  - With bypass, it is visible combinationally in the same cycle.
- Read latency is 0 cycles (combinational from raddr_i).

## Configuration
- KAMIKAZE_REGFILE_BYPASS_EN defined:
  - In READY, for each port, if we_i = 1, waddr_i ≠ 0 and raddr == waddr_i, rdata_o returns wdata_i in the same cycle.
  - The port-0 and x0 rules still take priority.
  - No bypass while ready_o = 0.
- Not defined: same-cycle read of an address being written returns the old contents. The new value appears after the edge.

## Test plan
- Reset release with NREGS=32: ready_o low for 31 edges, high after the 31st. Reads of addresses 1..31 then return 0x00000000.
- Write 0xDEADBEEF to x5, read x5 on both ports in the next cycle -> 0xDEADBEEF on both lanes. Write 0x12345678 to x0, read x0 -> 0.
- Bypass: same-cycle write x7 = 0xA5A5A5A5 while raddr port 1 = 7.
  - With KAMIKAZE_REGFILE_BYPASS_EN: rdata lane 1 = 0xA5A5A5A5 in that cycle.
  - Without it: the old value in that cycle, and 0xA5A5A5A5 the next cycle.
- Soft clear: fill x1..x31 with nonzero values, pulse clr_i one cycle with we_i = 1 to x3 = 0x1.
  - ready_o low 31 edges, all reads 0 meanwhile.
  - Afterwards all registers read 0, including x3.
- Clear restart: pulse clr_i at clear edge 10 -> ready_o stays low until 31 edges after the restart edge. Writes issued during the clear are lost.
- Async reset mid-clear: drop rst_ni at edge 15 -> ready_o and rdata_o go 0 immediately (no clock needed). After release, the full 31-edge clear runs.
